wb_spi_sram_responder: RTL and testbench

- Wishbone B4 slave that answers the Levenshtein engine's master port: 8-bit data, classic and incremental-burst cycles.
- Serves each access from an external SPI serial SRAM (23LC1024-style: READ 0x03, WRITE 0x02, 24-bit address, sequential mode).
- Keeps chip-select asserted across sequential accesses, so dictionary streaming costs one data byte per access instead of a full command.
- SCK rate is taken from the controller's 2-bit sram_config register.

---
 rtl/wb_spi_sram_responder.sv | 216 +++++++++++++++++++++
 tb/tb_wb_spi_sram_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_sram_responder.sv
// Wishbone B4 slave serving 8-bit accesses from a 23LC1024-style SPI serial SRAM.
// Chip-select stays low between sequential accesses so streaming costs one byte per beat.
module wb_spi_sram_responder #(
  parameter int         ADDR_WIDTH     = 24,
  parameter logic [7:0] CMD_READ       = 8'h03,
  parameter logic [7:0] CMD_WRITE      = 8'h02,
  parameter int         CS_IDLE_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic                  wbs_we_i,
  input  logic [7:0]            wbs_dat_i,
  input  logic [2:0]            wbs_cti_i,
  input  logic [1:0]            wbs_bte_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic                  wbs_rty_o,
  output logic [7:0]            wbs_dat_o,
  input  logic [1:0]            sram_config_i,
  output logic                  spi_sck_o,
  output logic                  spi_cs_n_o,
  output logic                  spi_mosi_o,
  input  logic                  spi_miso_i
);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, CMD, DATA, ACK, HOLD, CS_END
  } state_t;

  localparam int         AW_EXT      = (ADDR_WIDTH > 24) ? ADDR_WIDTH : 24;
  localparam logic [7:0] CS_END_LAST = 8'(CS_IDLE_CYCLES - 1);

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic                  we_q;
  logic [7:0]            dat_q;
  logic [2:0]            cti_q;
  logic [1:0]            h_sel_q;
  logic [2:0]            div_cnt_q;
  logic [4:0]            bit_cnt_q;
  logic [31:0]           shift_q;
  logic [7:0]            rx_q;
  logic                  aborted_q;
  logic [7:0]            end_cnt_q;

  logic [2:0]            half_m1;
  logic [AW_EXT-1:0]     addr_ext;
  logic [31:0]           cmd_word;
  logic                  req;
  logic                  unused;

  assign wbs_err_o = 1'b0;
  assign wbs_rty_o = 1'b0;
  assign unused    = ^wbs_bte_i;

  assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign addr_ext = AW_EXT'(addr_q);
  assign cmd_word = {(we_q ? CMD_WRITE : CMD_READ), addr_ext[23:0]};

  // SCK half-period is 2^h_sel clk cycles; the divider counts to half-1.
  always_comb begin
    half_m1 = 3'd0;
    case (h_sel_q)
      2'd0:    half_m1 = 3'd0;
      2'd1:    half_m1 = 3'd1;
      2'd2:    half_m1 = 3'd3;
      default: half_m1 = 3'd7;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      next_addr_q <= '0;
      we_q        <= 1'b0;
      dat_q       <= 8'h00;
      cti_q       <= 3'b000;
      h_sel_q     <= 2'd0;
      div_cnt_q   <= 3'd0;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 32'h0;
      rx_q        <= 8'h00;
      aborted_q   <= 1'b0;
      end_cnt_q   <= 8'd0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 8'h00;
      spi_sck_o   <= 1'b0;
      spi_cs_n_o  <= 1'b1;
      spi_mosi_o  <= 1'b0;
    end else begin
      wbs_ack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q     <= wbs_adr_i;
            we_q       <= wbs_we_i;
            dat_q      <= wbs_dat_i;
            cti_q      <= wbs_cti_i;
            h_sel_q    <= sram_config_i;
            aborted_q  <= 1'b0;
            spi_cs_n_o <= 1'b0;
            state_q    <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          shift_q    <= cmd_word;
          spi_mosi_o <= cmd_word[31];
          bit_cnt_q  <= 5'd31;
          div_cnt_q  <= 3'd0;
          spi_sck_o  <= 1'b0;
          state_q    <= CMD;
        end

        // Each bit: SCK low for H cycles, then high for H; MISO captured as SCK rises.
        CMD, DATA: begin
          if (!wbs_cyc_i) aborted_q <= 1'b1;
          if (!spi_sck_o) begin
            if (div_cnt_q == half_m1) begin
              spi_sck_o <= 1'b1;
              div_cnt_q <= 3'd0;
              rx_q      <= {rx_q[6:0], spi_miso_i};
            end else begin
              div_cnt_q <= div_cnt_q + 3'd1;
            end
          end else if (div_cnt_q != half_m1) begin
            div_cnt_q <= div_cnt_q + 3'd1;
          end else begin
            spi_sck_o <= 1'b0;
            div_cnt_q <= 3'd0;
            if (bit_cnt_q[2:0] == 3'd0 && (aborted_q || !wbs_cyc_i)) begin
              spi_cs_n_o <= 1'b1;
              spi_mosi_o <= 1'b0;
              end_cnt_q  <= 8'd0;
              state_q    <= CS_END;
            end else if (bit_cnt_q != 5'd0) begin
              bit_cnt_q  <= bit_cnt_q - 5'd1;
              shift_q    <= {shift_q[30:0], 1'b0};
              spi_mosi_o <= shift_q[30];
            end else if (state_q == CMD) begin
              shift_q    <= {(we_q ? dat_q : 8'h00), 24'h0};
              spi_mosi_o <= we_q & dat_q[7];
              bit_cnt_q  <= 5'd7;
              state_q    <= DATA;
            end else begin
              wbs_ack_o  <= 1'b1;
              if (!we_q) wbs_dat_o <= rx_q;
              spi_mosi_o <= 1'b0;
              state_q    <= ACK;
            end
          end
        end

        // A wrapped address is never continued sequentially.
        ACK: begin
          next_addr_q <= addr_q + ADDR_WIDTH'(1);
          if (cti_q == 3'b111 || &addr_q) begin
            spi_cs_n_o <= 1'b1;
            end_cnt_q  <= 8'd0;
            state_q    <= CS_END;
          end else begin
            state_q <= HOLD;
          end
        end

        HOLD: begin
          if (req) begin
            if (wbs_adr_i == next_addr_q && wbs_we_i == we_q) begin
              addr_q     <= wbs_adr_i;
              dat_q      <= wbs_dat_i;
              cti_q      <= wbs_cti_i;
              aborted_q  <= 1'b0;
              shift_q    <= {(wbs_we_i ? wbs_dat_i : 8'h00), 24'h0};
              spi_mosi_o <= wbs_we_i & wbs_dat_i[7];
              bit_cnt_q  <= 5'd7;
              div_cnt_q  <= 3'd0;
              spi_sck_o  <= 1'b0;
              state_q    <= DATA;
            end else begin
              spi_cs_n_o <= 1'b1;
              end_cnt_q  <= 8'd0;
              state_q    <= CS_END;
            end
          end
        end

        CS_END: begin
          if (end_cnt_q == CS_END_LAST) begin
            if (req) begin
              addr_q     <= wbs_adr_i;
              we_q       <= wbs_we_i;
              dat_q      <= wbs_dat_i;
              cti_q      <= wbs_cti_i;
              h_sel_q    <= sram_config_i;
              aborted_q  <= 1'b0;
              spi_cs_n_o <= 1'b0;
              state_q    <= CS_SETUP;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            end_cnt_q <= end_cnt_q + 8'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spi_sram_responder.sv
// Self-checking bench: behavioural 23LC1024 model on the SPI side, scoreboard of expected acks.
module tb_wb_spi_sram_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [23:0] adr = '0;
  logic [7:0]  wdat = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic [1:0]  cfg = 2'd0;
  logic        ack, err, rty, sck, cs_n, mosi;
  logic        miso = 1'b0;
  logic [7:0]  rdat_o;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] dat;
    int         lat;
    bit         rd;
  } exp_t;
  exp_t exp_q[$];

  wb_spi_sram_responder dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_adr_i(adr), .wbs_we_i(we),
    .wbs_dat_i(wdat), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty), .wbs_dat_o(rdat_o),
    .sram_config_i(cfg),
    .spi_sck_o(sck), .spi_cs_n_o(cs_n), .spi_mosi_o(mosi), .spi_miso_i(miso)
  );

  always #5 clk = ~clk;

  // SRAM model: command decode on rising SCK, read data driven on falling SCK.
  bit [7:0]   mem [bit [23:0]];
  int         m_bits = 0, m_dbit = 0, m_nb = 0;
  logic [31:0] m_cmd = '0;
  logic [7:0] m_op = '0, m_wsr = '0, m_bsr = '0, m_rb = '0;
  logic [23:0] m_addr = '0;
  logic [7:0] mosi_bytes[$];
  int         sck_pulses = 0;

  always @(negedge cs_n) begin
    m_bits = 0; m_dbit = 0; m_nb = 0;
    mosi_bytes.delete();
  end

  always @(posedge sck) begin
    sck_pulses++;
    if (!cs_n) begin
      m_bsr = {m_bsr[6:0], mosi};
      m_nb++;
      if (m_nb == 8) begin mosi_bytes.push_back(m_bsr); m_nb = 0; end
      if (m_bits < 32) begin
        m_cmd = {m_cmd[30:0], mosi};
        m_bits++;
        if (m_bits == 32) begin m_op = m_cmd[31:24]; m_addr = m_cmd[23:0]; m_dbit = 0; end
      end else begin
        m_wsr = {m_wsr[6:0], mosi};
        m_dbit++;
        if (m_dbit == 8) begin
          if (m_op == 8'h02) mem[m_addr] = m_wsr;
          m_addr++;
          m_dbit = 0;
        end
      end
    end
  end

  always @(negedge sck) begin
    if (!cs_n && m_bits == 32 && m_op == 8'h03) begin
      m_rb = mem[m_addr];
      miso = m_rb[7 - m_dbit];
    end
  end

  // Observers of SCK high time and chip-select idle time, sampled on falling clk.
  int hi_run = 0, last_hi = 0, cs_run = 0, last_cs_high = 0;
  always @(negedge clk) begin
    if (sck) hi_run++;
    else if (hi_run > 0) begin last_hi = hi_run; hi_run = 0; end
    if (cs_n) cs_run++;
    else if (cs_run > 0) begin last_cs_high = cs_run; cs_run = 0; end
  end

  function automatic logic [31:0] mosi_word(int start);
    if (mosi_bytes.size() < start + 4) return 32'hxxxxxxxx;
    return {mosi_bytes[start], mosi_bytes[start+1], mosi_bytes[start+2], mosi_bytes[start+3]};
  endfunction

  task automatic wb_access(input logic [23:0] a, input logic w, input logic [7:0] d,
                           input logic [2:0] c, output int lat, output logic [7:0] rd,
                           output bit timeout);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; wdat = d; cti = c;
    lat = 0; rd = 8'h00; timeout = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      @(negedge clk);
      if (ack) begin lat = i; rd = rdat_o; timeout = 1'b0; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
  endtask

  int lat; logic [7:0] rd; bit to; exp_t e;

  task automatic test_reset();
    #12;
    n_checks++; if ({cs_n, sck, mosi, ack, rdat_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00})
      $display("[TB] FAIL reset_outputs: got cs_n/sck/mosi/ack/dat=%b%b%b%b/%h required 1000/00", cs_n, sck, mosi, ack, rdat_o);
    else n_pass++;
    n_checks++; if ({err, rty} !== 2'b00) $display("[TB] FAIL err_rty_tied: got %b required 00", {err, rty});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_read_new();
    exp_q.push_back('{8'hA5, 82, 1'b1});
    wb_access(24'h000200, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat) $display("[TB] FAIL read_new_latency: got %0d required %0d", lat, e.lat);
    else n_pass++;
    n_checks++; if (rd !== e.dat) $display("[TB] FAIL read_new_data: got %h required %h", rd, e.dat);
    else n_pass++;
    n_checks++; if (mosi_word(0) !== 32'h03000200) $display("[TB] FAIL read_new_cmd: got %h required 03000200", mosi_word(0));
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (cs_n !== 1'b0) $display("[TB] FAIL hold_cs_low: got %b required 0", cs_n);
    else n_pass++;
  endtask

  task automatic test_sequential();
    sck_pulses = 0;
    exp_q.push_back('{8'h3C, 17, 1'b1});
    wb_access(24'h000201, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat) $display("[TB] FAIL seq_latency: got %0d required %0d", lat, e.lat);
    else n_pass++;
    n_checks++; if (rd !== e.dat) $display("[TB] FAIL seq_data: got %h required %h", rd, e.dat);
    else n_pass++;
    n_checks++; if (sck_pulses !== 8) $display("[TB] FAIL seq_sck_pulses: got %0d required 8", sck_pulses);
    else n_pass++;
    n_checks++; if (mosi_bytes.size() !== 6) $display("[TB] FAIL seq_no_cmd: got %0d bytes required 6", mosi_bytes.size());
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_new_command();
    exp_q.push_back('{8'hC3, 84, 1'b1});
    wb_access(24'h000700, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (last_cs_high !== 2) $display("[TB] FAIL cs_idle_cycles: got %0d required 2", last_cs_high);
    else n_pass++;
    n_checks++; if (to || lat !== e.lat) $display("[TB] FAIL new_cmd_latency: got %0d required %0d", lat, e.lat);
    else n_pass++;
    n_checks++; if (rd !== e.dat) $display("[TB] FAIL new_cmd_data: got %h required %h", rd, e.dat);
    else n_pass++;
    n_checks++; if (mosi_word(0) !== 32'h03000700) $display("[TB] FAIL new_cmd_mosi: got %h required 03000700", mosi_word(0));
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst_end();
    exp_q.push_back('{8'h96, 17, 1'b1});
    wb_access(24'h000701, 1'b0, 8'h00, 3'b111, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat || rd !== e.dat)
      $display("[TB] FAIL burst_end_beat: got lat %0d dat %h required lat %0d dat %h", lat, rd, e.lat, e.dat);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL burst_end_cs: got %b required 1", cs_n);
    else n_pass++;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_slow();
    cfg = 2'd2;
    exp_q.push_back('{8'h5A, 322, 1'b0});
    fork
      wb_access(24'h000010, 1'b1, 8'h5A, 3'b000, lat, rd, to);
      begin repeat (50) @(negedge clk); cfg = 2'd0; end
    join
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat) $display("[TB] FAIL write_latency: got %0d required %0d", lat, e.lat);
    else n_pass++;
    n_checks++; if (mosi_word(0) !== 32'h02000010 || mosi_bytes.size() < 5 || mosi_bytes[4] !== e.dat)
      $display("[TB] FAIL write_mosi: got %h/%0d bytes required 02000010 5a", mosi_word(0), mosi_bytes.size());
    else n_pass++;
    n_checks++; if (mem[24'h000010] !== e.dat) $display("[TB] FAIL write_mem: got %h required %h", mem[24'h000010], e.dat);
    else n_pass++;
    n_checks++; if (last_hi !== 4) $display("[TB] FAIL sck_half_period: got %0d required 4", last_hi);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap();
    exp_q.push_back('{8'h7E, 84, 1'b1});
    exp_q.push_back('{8'h81, 82, 1'b1});
    wb_access(24'hFFFFFF, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat || rd !== e.dat)
      $display("[TB] FAIL wrap_top: got lat %0d dat %h required lat %0d dat %h", lat, rd, e.lat, e.dat);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL wrap_cs_release: got %b required 1", cs_n);
    else n_pass++;
    repeat (4) @(negedge clk);
    wb_access(24'h000000, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat || rd !== e.dat)
      $display("[TB] FAIL wrap_zero: got lat %0d dat %h required lat %0d dat %h", lat, rd, e.lat, e.dat);
    else n_pass++;
    n_checks++; if (mosi_word(0) !== 32'h03000000) $display("[TB] FAIL wrap_new_cmd: got %h required 03000000", mosi_word(0));
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort();
    bit saw_ack = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 24'h000300; we = 1'b0; cti = 3'b000;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack) saw_ack = 1'b1;
      if (i == 10) begin cyc = 1'b0; stb = 1'b0; end
    end
    n_checks++; if (saw_ack !== 1'b0) $display("[TB] FAIL abort_no_ack: got %b required 0", saw_ack);
    else n_pass++;
    n_checks++; if (cs_n !== 1'b1) $display("[TB] FAIL abort_cs_release: got %b required 1", cs_n);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cmd();
    bit saw_ack = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; adr = 24'h000200; we = 1'b0; cti = 3'b000;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4 && !sck; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({cs_n, sck, ack} !== 3'b100) $display("[TB] FAIL reset_mid_cmd: got cs_n/sck/ack=%b%b%b required 100", cs_n, sck, ack);
    else n_pass++;
    cyc = 1'b0; stb = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack || !cs_n) saw_ack = 1'b1;
    end
    n_checks++; if (saw_ack !== 1'b0) $display("[TB] FAIL reset_no_ack: got activity %b required 0", saw_ack);
    else n_pass++;
    exp_q.push_back('{8'hA5, 82, 1'b1});
    wb_access(24'h000200, 1'b0, 8'h00, 3'b000, lat, rd, to);
    e = exp_q.pop_front();
    n_checks++; if (to || lat !== e.lat || rd !== e.dat)
      $display("[TB] FAIL reset_idle_restart: got lat %0d dat %h required lat %0d dat %h", lat, rd, e.lat, e.dat);
    else n_pass++;
  endtask

  initial begin
    mem[24'h000200] = 8'hA5;
    mem[24'h000201] = 8'h3C;
    mem[24'h000700] = 8'hC3;
    mem[24'h000701] = 8'h96;
    mem[24'hFFFFFF] = 8'h7E;
    mem[24'h000000] = 8'h81;
    mem[24'h000300] = 8'h11;
    $display("[TB] starting wb_spi_sram_responder bench");
    test_reset();
    test_read_new();
    test_sequential();
    test_new_command();
    test_burst_end();
    test_write_slow();
    test_wrap();
    test_abort();
    test_reset_mid_cmd();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
